// File: rtl/toy_bus_pkg.sv
// Shared constants for toy_bus nodes: id width, opcode encodings, default region map
// and the fill pattern used for locally generated error acks.
package toy_bus_pkg;

  localparam int ID_W_DEF     = 4;
  localparam int ADDR_W_DEF   = 32;
  localparam int N_REGION_DEF = 2;

  localparam logic OPC_READ  = 1'b0;
  localparam logic OPC_WRITE = 1'b1;

  // Entry 0 sits in the LSBs of each packed table.
  localparam logic [N_REGION_DEF*ADDR_W_DEF-1:0] REGION_BASE_DEF  = {32'hA000_0000, 32'h8000_0000};
  localparam logic [N_REGION_DEF*ADDR_W_DEF-1:0] REGION_LIMIT_DEF = {32'hC000_0000, 32'hA000_0000};
  localparam logic [N_REGION_DEF*ID_W_DEF-1:0]   REGION_TGT_DEF   = {4'd3, 4'd2};
  localparam int DEFAULT_TGT_DEF = 4;

  localparam logic ERR_FILL_BIT = 1'b1;

endpackage

// File: rtl/toy_bus_skid_buf.sv
// Two-entry skid buffer: registered ready, one-cycle latency, full throughput.
// Entry 0 drives the output; entry 1 absorbs the beat that arrives while entry 0 stalls.
module toy_bus_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_data,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_data
);

  logic         v0, v1, rdy_q;
  logic [W-1:0] d0, d1;
  logic         push, pop, v1_nxt, take0;

  assign push  = in_vld & rdy_q;
  assign pop   = v0 & out_rdy;
  assign take0 = ~v0 | pop;

  always_comb begin
    v1_nxt = v1;
    if (take0) v1_nxt = 1'b0;
    else if (push) v1_nxt = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0    <= 1'b0;
      v1    <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      if (take0) v0 <= v1 | push;
      v1    <= v1_nxt;
      rdy_q <= ~v1_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (take0) begin
      if (v1) d0 <= d1;
      else if (push) d0 <= in_data;
    end else if (push) begin
      d1 <= in_data;
    end
  end

  assign in_rdy   = rdy_q;
  assign out_vld  = v0;
  assign out_data = d0;

endmodule

// File: rtl/toy_bus_mst_node.sv
// Master-side toy_bus node: region decode, skid-buffered request path, outstanding cap,
// ack pass-through with misroute check. TOY_BUS_MST_NODE_DECERR_EN enables local decode-error acks.
module toy_bus_mst_node
  import toy_bus_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = 256,
  parameter int SB_W     = 32,
  parameter int ID_W     = ID_W_DEF,
  parameter int SRC_ID   = 0,
  parameter int N_REGION = N_REGION_DEF,
  parameter logic [N_REGION*ADDR_W-1:0] REGION_BASE  = REGION_BASE_DEF,
  parameter logic [N_REGION*ADDR_W-1:0] REGION_LIMIT = REGION_LIMIT_DEF,
  parameter logic [N_REGION*ID_W-1:0]   REGION_TGT   = REGION_TGT_DEF,
  parameter int DEFAULT_TGT = DEFAULT_TGT_DEF,
  parameter int MAX_OST     = 4,
  localparam int STRB_W = DATA_W / 8,
  localparam int CNT_W  = $clog2(MAX_OST + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_req_vld,
  output logic              in_req_rdy,
  input  logic [ADDR_W-1:0] in_req_addr,
  input  logic [DATA_W-1:0] in_req_data,
  input  logic [STRB_W-1:0] in_req_strb,
  input  logic              in_req_opcode,
  input  logic [SB_W-1:0]   in_req_sideband,
  output logic              in_ack_vld,
  input  logic              in_ack_rdy,
  output logic [DATA_W-1:0] in_ack_data,
  output logic [SB_W-1:0]   in_ack_sideband,
  output logic              in_ack_err,
  output logic              out_req_vld,
  input  logic              out_req_rdy,
  output logic [ADDR_W-1:0] out_req_addr,
  output logic [STRB_W-1:0] out_req_strb,
  output logic [DATA_W-1:0] out_req_data,
  output logic              out_req_opcode,
  output logic [SB_W-1:0]   out_req_sideband,
  output logic [ID_W-1:0]   out_req_src_id,
  output logic [ID_W-1:0]   out_req_tgt_id,
  input  logic              out_ack_vld,
  output logic              out_ack_rdy,
  input  logic              out_ack_opcode,
  input  logic [DATA_W-1:0] out_ack_data,
  input  logic [SB_W-1:0]   out_ack_sideband,
  input  logic [ID_W-1:0]   out_ack_src_id,
  input  logic [ID_W-1:0]   out_ack_tgt_id,
  output logic [CNT_W-1:0]  ost_cnt,
  output logic              misroute_err
);

  localparam int PW = 1 + ID_W + SB_W + 1 + STRB_W + DATA_W + ADDR_W;

  logic [ID_W-1:0] dec_tgt;
  logic            dec_hit;

  // Walk from the top so the lowest matching index is the one left standing.
  always_comb begin
    dec_tgt = ID_W'(DEFAULT_TGT);
    dec_hit = 1'b0;
    for (int i = N_REGION - 1; i >= 0; i--) begin
      if (in_req_addr >= REGION_BASE[i*ADDR_W +: ADDR_W] &&
          in_req_addr <  REGION_LIMIT[i*ADDR_W +: ADDR_W]) begin
        dec_tgt = REGION_TGT[i*ID_W +: ID_W];
        dec_hit = 1'b1;
      end
    end
  end

  logic [PW-1:0] skid_in, skid_out;
  logic          skid_vld, skid_rdy, head_hit, head_ok, loc_pop, at_max;
  logic          req_hs, ack_hs;

  assign skid_in = {dec_hit, dec_tgt, in_req_sideband, in_req_opcode, in_req_strb, in_req_data, in_req_addr};

  toy_bus_skid_buf #(.W(PW)) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_req_vld),
    .in_rdy   (in_req_rdy),
    .in_data  (skid_in),
    .out_vld  (skid_vld),
    .out_rdy  (skid_rdy),
    .out_data (skid_out)
  );

  assign {head_hit, out_req_tgt_id, out_req_sideband, out_req_opcode,
          out_req_strb, out_req_data, out_req_addr} = skid_out;
  assign out_req_src_id = ID_W'(SRC_ID);

  assign at_max      = (ost_cnt == CNT_W'(MAX_OST));
  assign out_req_vld = skid_vld & head_ok & ~at_max;
  assign skid_rdy    = (out_req_rdy & head_ok & ~at_max) | loc_pop;
  assign req_hs      = out_req_vld & out_req_rdy;
  assign ack_hs      = out_ack_vld & out_ack_rdy;

  logic ack_dec;
  assign ack_dec = ack_hs & (ost_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ost_cnt      <= '0;
      misroute_err <= 1'b0;
    end else begin
      if (req_hs && !ack_dec) ost_cnt <= ost_cnt + CNT_W'(1);
      else if (!req_hs && ack_dec) ost_cnt <= ost_cnt - CNT_W'(1);
      if ((out_ack_vld && out_ack_tgt_id != ID_W'(SRC_ID)) || (ack_hs && ost_cnt == '0))
        misroute_err <= 1'b1;
    end
  end

  logic unused_ok;

`ifdef TOY_BUS_MST_NODE_DECERR_EN
  logic            loc_vld;
  logic [SB_W-1:0] loc_sb;

  // An unmapped head only leaves once the network is drained, keeping ack order intact.
  assign loc_pop = skid_vld & ~head_hit & ~loc_vld & (ost_cnt == '0);
  assign head_ok = head_hit & ~loc_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loc_vld <= 1'b0;
      loc_sb  <= '0;
    end else if (loc_pop) begin
      loc_vld <= 1'b1;
      loc_sb  <= out_req_sideband;
    end else if (loc_vld && in_ack_rdy) begin
      loc_vld <= 1'b0;
    end
  end

  assign in_ack_vld      = loc_vld | out_ack_vld;
  assign in_ack_data     = loc_vld ? {DATA_W{ERR_FILL_BIT}} : out_ack_data;
  assign in_ack_sideband = loc_vld ? loc_sb : out_ack_sideband;
  assign in_ack_err      = loc_vld;
  assign out_ack_rdy     = in_ack_rdy & ~loc_vld;
  assign unused_ok       = ^{out_ack_opcode, out_ack_src_id};
`else
  assign loc_pop         = 1'b0;
  assign head_ok         = 1'b1;
  assign in_ack_vld      = out_ack_vld;
  assign in_ack_data     = out_ack_data;
  assign in_ack_sideband = out_ack_sideband;
  assign in_ack_err      = 1'b0;
  assign out_ack_rdy     = in_ack_rdy;
  assign unused_ok       = ^{out_ack_opcode, out_ack_src_id, head_hit};
`endif

endmodule

// File: tb/tb_toy_bus_mst_node.sv
// Self-checking bench for toy_bus_mst_node with a queue-based request scoreboard and
// an address-range reference decoder.
module tb_toy_bus_mst_node;

  localparam int SRC = 0;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_req_vld, in_req_rdy;
  logic [31:0]  in_req_addr;
  logic [255:0] in_req_data;
  logic [31:0]  in_req_strb;
  logic         in_req_opcode;
  logic [31:0]  in_req_sideband;
  logic         in_ack_vld, in_ack_rdy;
  logic [255:0] in_ack_data;
  logic [31:0]  in_ack_sideband;
  logic         in_ack_err;
  logic         out_req_vld, out_req_rdy;
  logic [31:0]  out_req_addr;
  logic [31:0]  out_req_strb;
  logic [255:0] out_req_data;
  logic         out_req_opcode;
  logic [31:0]  out_req_sideband;
  logic [3:0]   out_req_src_id, out_req_tgt_id;
  logic         out_ack_vld, out_ack_rdy;
  logic         out_ack_opcode;
  logic [255:0] out_ack_data;
  logic [31:0]  out_ack_sideband;
  logic [3:0]   out_ack_src_id, out_ack_tgt_id;
  logic [2:0]   ost_cnt;
  logic         misroute_err;

  toy_bus_mst_node dut (
    .clk(clk), .rst_n(rst_n),
    .in_req_vld(in_req_vld), .in_req_rdy(in_req_rdy), .in_req_addr(in_req_addr),
    .in_req_data(in_req_data), .in_req_strb(in_req_strb), .in_req_opcode(in_req_opcode),
    .in_req_sideband(in_req_sideband),
    .in_ack_vld(in_ack_vld), .in_ack_rdy(in_ack_rdy), .in_ack_data(in_ack_data),
    .in_ack_sideband(in_ack_sideband), .in_ack_err(in_ack_err),
    .out_req_vld(out_req_vld), .out_req_rdy(out_req_rdy), .out_req_addr(out_req_addr),
    .out_req_strb(out_req_strb), .out_req_data(out_req_data), .out_req_opcode(out_req_opcode),
    .out_req_sideband(out_req_sideband), .out_req_src_id(out_req_src_id),
    .out_req_tgt_id(out_req_tgt_id),
    .out_ack_vld(out_ack_vld), .out_ack_rdy(out_ack_rdy), .out_ack_opcode(out_ack_opcode),
    .out_ack_data(out_ack_data), .out_ack_sideband(out_ack_sideband),
    .out_ack_src_id(out_ack_src_id), .out_ack_tgt_id(out_ack_tgt_id),
    .ost_cnt(ost_cnt), .misroute_err(misroute_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]  addr;
    logic [255:0] data;
    logic [31:0]  strb;
    logic         opc;
    logic [31:0]  sb;
    logic [3:0]   tgt;
    logic [3:0]   src;
  } beat_t;

  beat_t drv_q[$];
  beat_t exp_q[$];
  beat_t obs_q[$];

  int   errors = 0;
  int   checks = 0;
  logic rand_rdy = 1'b0;
  logic rdy_fixed = 1'b1;
  logic req_hs_seen = 1'b0;
  logic held_vld = 1'b0;
  beat_t held;

  function automatic logic [3:0] ref_tgt(input logic [31:0] a);
    if (a >= 32'h8000_0000 && a < 32'hA000_0000) return 4'd2;
    if (a >= 32'hA000_0000 && a < 32'hC000_0000) return 4'd3;
    return 4'd4;
  endfunction

  function automatic beat_t mk_beat(input logic [31:0] a);
    beat_t b;
    b.addr = a;
    b.data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    b.strb = $urandom;
    b.opc  = 1'($urandom % 2);
    b.sb   = $urandom;
    b.tgt  = ref_tgt(a);
    b.src  = 4'(SRC);
    return b;
  endfunction

  function automatic beat_t out_beat();
    beat_t b;
    b.addr = out_req_addr;
    b.data = out_req_data;
    b.strb = out_req_strb;
    b.opc  = out_req_opcode;
    b.sb   = out_req_sideband;
    b.tgt  = out_req_tgt_id;
    b.src  = out_req_src_id;
    return b;
  endfunction

  function automatic logic [31:0] rand_mapped();
    return 32'h8000_0000 + ($urandom % 32'h4000_0000);
  endfunction

  // Core-side request driver and network-side ready driver.
  initial begin
    in_req_vld = 0; in_req_addr = 0; in_req_data = 0; in_req_strb = 0;
    in_req_opcode = 0; in_req_sideband = 0; out_req_rdy = 0;
    forever begin
      @(posedge clk);
      if (req_hs_seen && drv_q.size() > 0) void'(drv_q.pop_front());
      #1;
      if (rst_n && drv_q.size() > 0) begin
        in_req_vld      = 1'b1;
        in_req_addr     = drv_q[0].addr;
        in_req_data     = drv_q[0].data;
        in_req_strb     = drv_q[0].strb;
        in_req_opcode   = drv_q[0].opc;
        in_req_sideband = drv_q[0].sb;
      end else begin
        in_req_vld = 1'b0;
      end
      out_req_rdy = rand_rdy ? 1'($urandom % 2) : rdy_fixed;
    end
  end

  // Network-side monitor: records accepted beats, checks held beats stay stable.
  always @(negedge clk) begin
    beat_t cur;
    req_hs_seen = rst_n && in_req_vld && in_req_rdy;
    if (!rst_n) held_vld = 1'b0;
    else if (out_req_vld) begin
      cur = out_beat();
      if (held_vld) begin
        checks++;
        if (cur !== held) begin
          errors++;
          $display("FAIL hold_stable got addr=%h tgt=%0d exp addr=%h tgt=%0d", cur.addr, cur.tgt, held.addr, held.tgt);
        end
      end
      if (out_req_rdy) begin
        obs_q.push_back(cur);
        held_vld = 1'b0;
      end else begin
        held = cur;
        held_vld = 1'b1;
      end
    end
  end

  task automatic push_req(input beat_t b, input logic expect_fwd);
    drv_q.push_back(b);
    if (expect_fwd) exp_q.push_back(b);
  endtask

  task automatic wait_obs(input int n, input int lim);
    int c = 0;
    while (obs_q.size() < n && c < lim) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic send_ack(input logic [3:0] tgt);
    logic [255:0] d;
    logic [31:0]  sb;
    d  = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    sb = $urandom;
    @(posedge clk); #1;
    out_ack_vld = 1'b1; out_ack_data = d; out_ack_sideband = sb;
    out_ack_tgt_id = tgt; out_ack_src_id = 4'($urandom); out_ack_opcode = 1'($urandom % 2);
    @(negedge clk);
    checks++;
    if (in_ack_vld !== 1'b1 || in_ack_data !== d || in_ack_sideband !== sb ||
        in_ack_err !== 1'b0 || out_ack_rdy !== 1'b1) begin
      errors++;
      $display("FAIL ack_fwd got vld=%b err=%b rdy=%b sb=%h exp vld=1 err=0 rdy=1 sb=%h",
               in_ack_vld, in_ack_err, out_ack_rdy, in_ack_sideband, sb);
    end
    @(posedge clk); #1;
    out_ack_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    checks++;
    if (in_req_rdy !== 0 || out_req_vld !== 0 || ost_cnt !== 0 || misroute_err !== 0 || in_ack_vld !== 0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b vld=%b ost=%0d mis=%b ackv=%b exp all 0",
               in_req_rdy, out_req_vld, ost_cnt, misroute_err, in_ack_vld);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (in_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_rdy_low got %b exp 0", in_req_rdy);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_release got %b exp 1", in_req_rdy);
    end
  endtask

  task automatic test_single();
    beat_t b;
    int n;
    rand_rdy = 0; rdy_fixed = 1;
    repeat (2) @(posedge clk);
    b = mk_beat(32'h8000_0010);
    b.opc = 1'b1;
    push_req(b, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(in_req_vld && in_req_rdy) && n < 10);
    @(negedge clk);
    checks++;
    if (out_req_vld !== 1'b1) begin
      errors++;
      $display("FAIL single_latency got vld=%b exp 1 one clk after accept", out_req_vld);
    end
    checks++;
    if (out_beat() !== b || out_req_tgt_id !== 4'd2) begin
      errors++;
      $display("FAIL single_payload got addr=%h tgt=%0d src=%0d exp addr=%h tgt=2 src=%0d",
               out_req_addr, out_req_tgt_id, out_req_src_id, b.addr, SRC);
    end
    @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd1) begin
      errors++;
      $display("FAIL single_ost got %0d exp 1", ost_cnt);
    end
    send_ack(4'(SRC));
    @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd0) begin
      errors++;
      $display("FAIL single_ost_ret got %0d exp 0", ost_cnt);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_boundary();
    logic [31:0] addrs[$];
    logic [3:0]  tgts[$];
    beat_t b;
`ifdef TOY_BUS_MST_NODE_DECERR_EN
    addrs = '{32'h9FFF_FFFF, 32'hA000_0000, 32'hBFFF_FFFF};
    tgts  = '{4'd2, 4'd3, 4'd3};
`else
    addrs = '{32'h9FFF_FFFF, 32'hA000_0000, 32'hBFFF_FFFF, 32'hC000_0000};
    tgts  = '{4'd2, 4'd3, 4'd3, 4'd4};
`endif
    foreach (addrs[i]) begin
      b = mk_beat(addrs[i]);
      push_req(b, 1'b1);
    end
    wait_obs(addrs.size(), 40);
    checks++;
    if (obs_q.size() != addrs.size()) begin
      errors++;
      $display("FAIL boundary_count got %0d exp %0d", obs_q.size(), addrs.size());
    end
    for (int i = 0; i < obs_q.size() && i < addrs.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i] || obs_q[i].tgt !== tgts[i]) begin
        errors++;
        $display("FAIL boundary[%0d] got addr=%h tgt=%0d exp addr=%h tgt=%0d",
                 i, obs_q[i].addr, obs_q[i].tgt, exp_q[i].addr, tgts[i]);
      end
    end
    foreach (addrs[i]) send_ack(4'(SRC));
    @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd0) begin
      errors++;
      $display("FAIL boundary_ost got %0d exp 0", ost_cnt);
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_back_to_back();
    rand_rdy = 1;
    for (int i = 0; i < 8; i++) push_req(mk_beat(rand_mapped()), 1'b1);
    wait_obs(4, 80);
    repeat (10) @(negedge clk);
    checks++;
    if (obs_q.size() != 4 || ost_cnt !== 3'd4 || out_req_vld !== 1'b0 || in_req_rdy !== 1'b0) begin
      errors++;
      $display("FAIL ost_cap got fwd=%0d ost=%0d vld=%b rdy=%b exp fwd=4 ost=4 vld=0 rdy=0",
               obs_q.size(), ost_cnt, out_req_vld, in_req_rdy);
    end
    rand_rdy = 0; rdy_fixed = 1;
    send_ack(4'(SRC));
    wait_obs(5, 10);
    repeat (2) @(negedge clk);
    checks++;
    if (obs_q.size() != 5 || ost_cnt !== 3'd4) begin
      errors++;
      $display("FAIL release_one got fwd=%0d ost=%0d exp fwd=5 ost=4", obs_q.size(), ost_cnt);
    end
    for (int k = 0; k < 7; k++) begin
      send_ack(4'(SRC));
      repeat (3) @(negedge clk);
    end
    checks++;
    if (obs_q.size() != 8 || ost_cnt !== 3'd0) begin
      errors++;
      $display("FAIL b2b_drain got fwd=%0d ost=%0d exp fwd=8 ost=0", obs_q.size(), ost_cnt);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_order[%0d] got addr=%h sb=%h exp addr=%h sb=%h",
                 i, obs_q[i].addr, obs_q[i].sb, exp_q[i].addr, exp_q[i].sb);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_simul_misroute();
    int n;
    rand_rdy = 0; rdy_fixed = 1;
    push_req(mk_beat(rand_mapped()), 1'b1);
    push_req(mk_beat(rand_mapped()), 1'b1);
    wait_obs(2, 20);
    @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd2) begin
      errors++;
      $display("FAIL simul_pre_ost got %0d exp 2", ost_cnt);
    end
    @(posedge clk);
    push_req(mk_beat(rand_mapped()), 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_req_vld && n < 10);
    out_ack_vld = 1'b1; out_ack_tgt_id = 4'(SRC);
    @(posedge clk); #1;
    out_ack_vld = 1'b0;
    @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd2 || obs_q.size() != 3) begin
      errors++;
      $display("FAIL simul_hs got ost=%0d fwd=%0d exp ost=2 fwd=3", ost_cnt, obs_q.size());
    end
    send_ack(4'd5);
    @(negedge clk);
    checks++;
    if (misroute_err !== 1'b1 || ost_cnt !== 3'd1) begin
      errors++;
      $display("FAIL misroute got mis=%b ost=%0d exp mis=1 ost=1", misroute_err, ost_cnt);
    end
    send_ack(4'(SRC));
    repeat (3) @(negedge clk);
    checks++;
    if (misroute_err !== 1'b1 || ost_cnt !== 3'd0) begin
      errors++;
      $display("FAIL misroute_sticky got mis=%b ost=%0d exp mis=1 ost=0", misroute_err, ost_cnt);
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL simul_order[%0d] got addr=%h exp addr=%h", i, obs_q[i].addr, exp_q[i].addr);
      end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_reset_mid();
    beat_t b;
    rand_rdy = 0; rdy_fixed = 1;
    for (int i = 0; i < 3; i++) push_req(mk_beat(rand_mapped()), 1'b1);
    wait_obs(3, 20);
    rdy_fixed = 0;
    repeat (2) @(posedge clk);
    for (int i = 0; i < 4; i++) push_req(mk_beat(rand_mapped()), 1'b1);
    repeat (8) @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd3 || in_req_rdy !== 1'b0 || out_req_vld !== 1'b1 || misroute_err !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got ost=%0d rdy=%b vld=%b mis=%b exp ost=3 rdy=0 vld=1 mis=1",
               ost_cnt, in_req_rdy, out_req_vld, misroute_err);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    drv_q.delete(); exp_q.delete(); obs_q.delete();
    #1;
    checks++;
    if (out_req_vld !== 0 || in_req_rdy !== 0 || ost_cnt !== 0 || misroute_err !== 0 || in_ack_vld !== 0) begin
      errors++;
      $display("FAIL mid_reset got vld=%b rdy=%b ost=%0d mis=%b exp all 0",
               out_req_vld, in_req_rdy, ost_cnt, misroute_err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rdy_fixed = 1;
    repeat (2) @(posedge clk);
    send_ack(4'(SRC));
    @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd0 || misroute_err !== 1'b1) begin
      errors++;
      $display("FAIL underflow got ost=%0d mis=%b exp ost=0 mis=1", ost_cnt, misroute_err);
    end
    b = mk_beat(rand_mapped());
    push_req(b, 1'b1);
    wait_obs(1, 20);
    @(negedge clk);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== b || ost_cnt !== 3'd1) begin
      errors++;
      $display("FAIL post_reset_req got fwd=%0d ost=%0d exp fwd=1 ost=1 addr=%h", obs_q.size(), ost_cnt, b.addr);
    end
    send_ack(4'(SRC));
    exp_q.delete(); obs_q.delete();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
  endtask

`ifdef TOY_BUS_MST_NODE_DECERR_EN
  task automatic test_decerr();
    beat_t b;
    int n;
    rand_rdy = 0; rdy_fixed = 1;
    push_req(mk_beat(rand_mapped()), 1'b1);
    push_req(mk_beat(rand_mapped()), 1'b1);
    b = mk_beat(32'h0000_1000);
    push_req(b, 1'b0);
    wait_obs(2, 20);
    repeat (6) @(negedge clk);
    checks++;
    if (ost_cnt !== 3'd2 || in_ack_vld !== 1'b0 || out_req_vld !== 1'b0 || obs_q.size() != 2) begin
      errors++;
      $display("FAIL decerr_hold got ost=%0d ackv=%b vld=%b fwd=%0d exp ost=2 ackv=0 vld=0 fwd=2",
               ost_cnt, in_ack_vld, out_req_vld, obs_q.size());
    end
    send_ack(4'(SRC));
    send_ack(4'(SRC));
    n = 0;
    while (!in_ack_vld && n < 10) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (in_ack_vld !== 1'b1 || in_ack_err !== 1'b1 || in_ack_data !== {256{1'b1}} ||
        in_ack_sideband !== b.sb || out_ack_rdy !== 1'b0) begin
      errors++;
      $display("FAIL decerr_ack got vld=%b err=%b sb=%h nrdy=%b exp vld=1 err=1 sb=%h nrdy=0",
               in_ack_vld, in_ack_err, in_ack_sideband, out_ack_rdy, b.sb);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (obs_q.size() != 2 || ost_cnt !== 3'd0 || in_ack_vld !== 1'b0) begin
      errors++;
      $display("FAIL decerr_after got fwd=%0d ost=%0d ackv=%b exp fwd=2 ost=0 ackv=0",
               obs_q.size(), ost_cnt, in_ack_vld);
    end
    exp_q.delete(); obs_q.delete();
  endtask
`endif

  initial begin
    in_ack_rdy = 1'b1; out_ack_vld = 0; out_ack_opcode = 0; out_ack_data = 0;
    out_ack_sideband = 0; out_ack_src_id = 0; out_ack_tgt_id = 0;
    test_reset();
    test_single();
    test_boundary();
    test_back_to_back();
    test_simul_misroute();
    test_reset_mid();
`ifdef TOY_BUS_MST_NODE_DECERR_EN
    test_decerr();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
